// File: rtl/exec_stage_mc_if.sv
// exec_stage_mc_if: bundle issue/retire interface for exec_stage_mc.
// Channel c uses bits [c*W+W-1:c*W] of the data buses and bits [c*4+3:c*4] of the register-number buses.
interface exec_stage_mc_if #(
  parameter int CH = 2,
  parameter int W  = 32
);

  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [CH*3-1:0] op;
  logic [CH*4-1:0] wn;
  logic [CH-1:0]   wreg;
  logic [CH*W-1:0] da;
  logic [CH*W-1:0] db;
  logic [CH*4-1:0] rn_a;
  logic [CH*4-1:0] rn_b;
  logic            out_valid;
  logic [CH*W-1:0] ed;
  logic [CH*4-1:0] ewn;
  logic [CH-1:0]   ewreg;
  logic [CH-1:0]   neg;
  logic [CH-1:0]   zero;

  modport master (
    output in_valid, flush, op, wn, wreg, da, db, rn_a, rn_b,
    input  in_ready, out_valid, ed, ewn, ewreg, neg, zero
  );

  modport slave (
    input  in_valid, flush, op, wn, wreg, da, db, rn_a, rn_b,
    output in_ready, out_valid, ed, ewn, ewreg, neg, zero
  );

endinterface

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: multi-channel execute stage; ALU bundles retire next cycle, MUL bundles after MUL_LAT cycles.
// Optional feature macro EXEC_STAGE_MC_BYPASS_EN forwards the retiring results into a bundle accepted alongside them.
module exec_stage_mc #(
  parameter int CH      = 2,
  parameter int W       = 32,
  parameter int MUL_LAT = 3
) (
  input  logic           clock,
  input  logic           nReset,
  exec_stage_mc_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic outValid_q, outValid_d;

  logic [CH-1:0][W-1:0] ed_q, ed_d;
  logic [CH-1:0][3:0]   ewn_q, ewn_d;
  logic [CH-1:0]        wregRet_q, wregRet_d;

  logic [CH-1:0][W-1:0] pendEd_q, pendEd_d;
  logic [CH-1:0][3:0]   pendWn_q, pendWn_d;
  logic [CH-1:0]        pendWreg_q, pendWreg_d;

  logic [CH-1:0][2:0]   opCh;
  logic [CH-1:0][3:0]   wnCh;
  logic [CH-1:0][3:0]   rnA;
  logic [CH-1:0][3:0]   rnB;
  logic [CH-1:0][W-1:0] opA;
  logic [CH-1:0][W-1:0] opB;
  logic [CH-1:0][W-1:0] result;
  logic [CH-1:0]        wregEff;
  logic [CH-1:0]        zeroV;
  logic [CH-1:0]        negV;
  logic                 anyMul;
  logic                 inReady;
  logic                 accept;

  assign opCh = bus.op;
  assign wnCh = bus.wn;
  assign rnA  = bus.rn_a;
  assign rnB  = bus.rn_b;

  assign inReady = (state_q == IDLE);
  assign accept  = bus.in_valid & inReady & ~bus.flush;

  function automatic logic [W-1:0] aluResult(input logic [2:0] opc,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (opc)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOV:  r = a;
      OP_MUL:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Forwarding only ever sees the bundle retiring this cycle; later channels override earlier matches.
  always_comb begin
    opA = bus.da;
    opB = bus.db;
`ifdef EXEC_STAGE_MC_BYPASS_EN
    if (outValid_q) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < CH; k++) begin
          if (wregRet_q[k] && (ewn_q[k] == rnA[c])) opA[c] = ed_q[k];
          if (wregRet_q[k] && (ewn_q[k] == rnB[c])) opB[c] = ed_q[k];
        end
      end
    end
`endif
  end

`ifndef EXEC_STAGE_MC_BYPASS_EN
  logic unusedRn;
  assign unusedRn = ^{rnA, rnB};
`endif

  always_comb begin
    anyMul  = 1'b0;
    result  = '0;
    wregEff = '0;
    for (int c = 0; c < CH; c++) begin
      result[c]  = aluResult(opCh[c], opA[c], opB[c]);
      wregEff[c] = bus.wreg[c] & (opCh[c] != OP_NOP);
      if (opCh[c] == OP_MUL) anyMul = 1'b1;
    end
  end

  // A MUL anywhere in the bundle parks every channel's result until the whole bundle retires together.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    outValid_d = 1'b0;
    ed_d       = ed_q;
    ewn_d      = ewn_q;
    wregRet_d  = wregRet_q;
    pendEd_d   = pendEd_q;
    pendWn_d   = pendWn_q;
    pendWreg_d = pendWreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (anyMul) begin
            state_d    = BUSY;
            cnt_d      = CNT_LOAD;
            pendEd_d   = result;
            pendWn_d   = wnCh;
            pendWreg_d = wregEff;
          end else begin
            ed_d       = result;
            ewn_d      = wnCh;
            wregRet_d  = wregEff;
            outValid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d    = IDLE;
          cnt_d      = 4'd0;
          ed_d       = pendEd_q;
          ewn_d      = pendWn_q;
          wregRet_d  = pendWreg_q;
          outValid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      outValid_q <= 1'b0;
      ed_q       <= '0;
      ewn_q      <= '0;
      wregRet_q  <= '0;
      pendEd_q   <= '0;
      pendWn_q   <= '0;
      pendWreg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      ed_q       <= ed_d;
      ewn_q      <= ewn_d;
      wregRet_q  <= wregRet_d;
      pendEd_q   <= pendEd_d;
      pendWn_q   <= pendWn_d;
      pendWreg_q <= pendWreg_d;
    end
  end

  always_comb begin
    zeroV = '0;
    negV  = '0;
    for (int c = 0; c < CH; c++) begin
      zeroV[c] = ~|ed_q[c];
      negV[c]  = ed_q[c][W-1];
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.ed        = ed_q;
  assign bus.ewn       = ewn_q;
  assign bus.ewreg     = wregRet_q & {CH{outValid_q}};
  assign bus.zero      = zeroV;
  assign bus.neg       = negV;

endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc: randomized bundles scored against a transaction-level model; a monitor pops expected retires.
// Builds with or without EXEC_STAGE_MC_BYPASS_EN; the model forwards only in the bypass build.
module tb_exec_stage_mc;

  localparam int CH  = 2;
  localparam int W   = 32;
  localparam int L   = 3;
  localparam int OPW = CH * 3;

  localparam int NO_FLUSH   = -1;
  localparam int IDLE_FLUSH = -2;
  localparam int RESET_MID  = -3;

  typedef struct {
    int                   cyc;
    logic [CH-1:0][W-1:0] ed;
    logic [CH-1:0][3:0]   ewn;
    logic [CH-1:0]        ewreg;
  } exp_t;

  logic clock  = 1'b0;
  logic nReset = 1'b0;

  int cyc        = 0;
  int nChecks    = 0;
  int nPass      = 0;
  int readyFrom  = 0;
  int lastRetCyc = -10;

  exp_t lastRet;
  exp_t expQ[$];

  logic [CH-1:0][W-1:0] heldEd  = '0;
  logic [CH-1:0][3:0]   heldEwn = '0;

  exec_stage_mc_if #(.CH(CH), .W(W)) bus ();

  exec_stage_mc #(.CH(CH), .W(W), .MUL_LAT(L)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  function automatic logic [W-1:0] refAlu(input int opc, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned x, y, mask;
    x    = a;
    y    = b;
    mask = (64'd1 << W) - 64'd1;
    case (opc)
      0:       return W'((x + y) & mask);
      1:       return W'((x - y) & mask);
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return a;
      6:       return W'((x * y) & mask);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CH-1:0] refZero(input logic [CH-1:0][W-1:0] ed);
    logic [CH-1:0] z;
    for (int c = 0; c < CH; c++) z[c] = (ed[c] == '0);
    return z;
  endfunction

  function automatic logic [CH-1:0] refNeg(input logic [CH-1:0][W-1:0] ed);
    logic [CH-1:0] n;
    longint unsigned v;
    for (int c = 0; c < CH; c++) begin
      v    = ed[c];
      n[c] = (v >= (64'd1 << (W - 1)));
    end
    return n;
  endfunction

  function automatic exp_t predict(input logic [CH-1:0][2:0] opV, input logic [CH-1:0][W-1:0] daV,
                                   input logic [CH-1:0][W-1:0] dbV, input logic [CH-1:0][3:0] wnV,
                                   input logic [CH-1:0][3:0] rnaV, input logic [CH-1:0][3:0] rnbV,
                                   input logic [CH-1:0] wregV, input bit fwd);
    exp_t e;
    logic [W-1:0] a, b;
    e.cyc = 0;
    for (int c = 0; c < CH; c++) begin
      a = daV[c];
      b = dbV[c];
      if (fwd) begin
        for (int k = 0; k < CH; k++) begin
          if (lastRet.ewreg[k] && lastRet.ewn[k] == rnaV[c]) a = lastRet.ed[k];
          if (lastRet.ewreg[k] && lastRet.ewn[k] == rnbV[c]) b = lastRet.ed[k];
        end
      end
      e.ed[c]    = refAlu(int'(opV[c]), a, b);
      e.ewn[c]   = wnV[c];
      e.ewreg[c] = wregV[c] && (opV[c] != 3'd7);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic stepCycle();
    @(negedge clock);
    checkOutput("in_ready", 128'(bus.in_ready), 128'(cyc >= readyFrom));
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = OPW'($urandom);
    for (int c = 0; c < CH; c++) begin
      bus.da[c*W +: W] = W'($urandom);
      bus.db[c*W +: W] = W'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0][2:0] opV, input logic [CH-1:0][W-1:0] daV,
                               input logic [CH-1:0][W-1:0] dbV, input logic [CH-1:0][3:0] wnV,
                               input logic [CH-1:0][3:0] rnaV, input logic [CH-1:0][3:0] rnbV,
                               input logic [CH-1:0] wregV, input int gap, input int mode);
    exp_t e;
    int   x, a;
    bit   mul, fwd;
    repeat (gap) stepCycle();
    stepCycle();
    while (cyc < readyFrom) stepCycle();
    x            = cyc;
    bus.in_valid = 1'b1;
    bus.op       = opV;
    bus.da       = daV;
    bus.db       = dbV;
    bus.wn       = wnV;
    bus.rn_a     = rnaV;
    bus.rn_b     = rnbV;
    bus.wreg     = wregV;
    if (mode == IDLE_FLUSH) begin
      bus.flush = 1'b1;
      return;
    end
    a   = x + 1;
    mul = 1'b0;
    for (int c = 0; c < CH; c++) if (opV[c] == 3'd6) mul = 1'b1;
    fwd = 1'b0;
`ifdef EXEC_STAGE_MC_BYPASS_EN
    fwd = (lastRetCyc == x);
`endif
    e         = predict(opV, daV, dbV, wnV, rnaV, rnbV, wregV, fwd);
    readyFrom = mul ? a + L - 1 : a;
    if (mul && mode >= 0) begin
      while (cyc < a + mode) stepCycle();
      bus.flush = 1'b1;
      readyFrom = a + mode + 1;
    end else if (mul && mode == RESET_MID) begin
      while (cyc < a) stepCycle();
      #2 nReset = 1'b0;
      #1;
      checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      checkOutput("rst_zero", 128'(bus.zero), 128'({CH{1'b1}}));
      checkOutput("rst_neg", 128'(bus.neg), 128'(0));
      checkOutput("rst_ed", 128'(bus.ed), 128'(0));
      checkOutput("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
      heldEd     = '0;
      heldEwn    = '0;
      readyFrom  = 0;
      lastRetCyc = -10;
      @(negedge clock);
      #2 nReset = 1'b1;
    end else begin
      e.cyc      = mul ? a + L - 1 : a;
      expQ.push_back(e);
      lastRet    = e;
      lastRetCyc = e.cyc;
    end
  endtask

  // Retires must land exactly on the predicted cycle; between retires results hold and ewreg stays low.
  always @(negedge clock) begin
    exp_t e;
    logic expValid;
    if (nReset) begin
      expValid = (expQ.size() > 0) && (expQ[0].cyc == cyc);
      checkOutput("out_valid", 128'(bus.out_valid), 128'(expValid));
      if (expValid) begin
        e = expQ.pop_front();
        checkOutput("ed", 128'(bus.ed), 128'(e.ed));
        checkOutput("ewn", 128'(bus.ewn), 128'(e.ewn));
        checkOutput("ewreg", 128'(bus.ewreg), 128'(e.ewreg));
        heldEd  = e.ed;
        heldEwn = e.ewn;
      end else begin
        checkOutput("ed_hold", 128'(bus.ed), 128'(heldEd));
        checkOutput("ewn_hold", 128'(bus.ewn), 128'(heldEwn));
        checkOutput("ewreg_idle", 128'(bus.ewreg), 128'(0));
      end
      checkOutput("zero", 128'(bus.zero), 128'(refZero(heldEd)));
      checkOutput("neg", 128'(bus.neg), 128'(refNeg(heldEd)));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [CH-1:0][2:0]   o;
    logic [CH-1:0][W-1:0] va, vb;
    logic [CH-1:0][3:0]   wn, rna, rnb;
    logic [CH-1:0]        wr;
    int                   gap, mode;
    bit                   hasMul;

    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = '0;
    bus.wn       = '0;
    bus.wreg     = '0;
    bus.da       = '0;
    bus.db       = '0;
    bus.rn_a     = '0;
    bus.rn_b     = '0;

    repeat (2) @(negedge clock);
    checkOutput("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    checkOutput("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    checkOutput("reset_ed", 128'(bus.ed), 128'(0));
    checkOutput("reset_ewn", 128'(bus.ewn), 128'(0));
    checkOutput("reset_ewreg", 128'(bus.ewreg), 128'(0));
    checkOutput("reset_zero", 128'(bus.zero), 128'({CH{1'b1}}));
    checkOutput("reset_neg", 128'(bus.neg), 128'(0));
    #2 nReset = 1'b1;

    // ch0 ADD wraps to zero, ch1 SUB goes negative
    applyStimulus({3'd1, 3'd0}, {32'd5, 32'hFFFF_FFFF}, {32'd7, 32'd1}, {4'd2, 4'd1}, '0, '0, 2'b11, 0, NO_FLUSH);
    // ch0 MUL overflows to zero, ch1 MOV 9; back-to-back with the previous retire
    applyStimulus({3'd5, 3'd6}, {32'd9, 32'h1_0000}, {32'd0, 32'h1_0000}, {4'd4, 4'd3}, '0, '0, 2'b11, 0, NO_FLUSH);
    // MUL flushed one cycle after acceptance
    applyStimulus({3'd6, 3'd6}, {32'd3, 32'd4}, {32'd5, 32'd6}, {4'd5, 4'd6}, '0, '0, 2'b11, 1, 0);
    // MUL flushed on its retire edge
    applyStimulus({3'd0, 3'd6}, {32'd3, 32'd4}, {32'd5, 32'd6}, {4'd5, 4'd6}, '0, '0, 2'b11, 0, L - 2);
    // flush while idle blocks acceptance
    applyStimulus({3'd0, 3'd0}, {32'd1, 32'd1}, {32'd1, 32'd1}, {4'd7, 4'd7}, '0, '0, 2'b11, 0, IDLE_FLUSH);
    // two channels retire to r3; next bundle reads r3 on ch0 in the retire cycle
    applyStimulus({3'd5, 3'd5}, {32'h20, 32'h10}, '0, {4'd3, 4'd3}, '0, '0, 2'b11, 1, NO_FLUSH);
    applyStimulus({3'd7, 3'd0}, {32'd0, 32'd0}, {32'd0, 32'd1}, {4'd0, 4'd1}, {4'd0, 4'd3}, {4'd0, 4'd0},
                  2'b01, 0, NO_FLUSH);

    for (int n = 0; n < 200; n++) begin
      hasMul = 1'b0;
      for (int c = 0; c < CH; c++) begin
        o[c]   = 3'($urandom_range(0, 7));
        va[c]  = pickOperand();
        vb[c]  = pickOperand();
        wn[c]  = 4'($urandom_range(0, 3));
        rna[c] = 4'($urandom_range(0, 4));
        rnb[c] = 4'($urandom_range(0, 4));
        if (o[c] == 3'd6) hasMul = 1'b1;
      end
      wr   = CH'($urandom);
      gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      mode = NO_FLUSH;
      if (hasMul && $urandom_range(0, 4) == 0) mode = int'($urandom_range(0, L - 2));
      else if ($urandom_range(0, 11) == 0) mode = IDLE_FLUSH;
      applyStimulus(o, va, vb, wn, rna, rnb, wr, gap, mode);
    end

    // reset in the middle of a MUL bundle, then a NOP bundle retires with ewreg low
    applyStimulus({3'd0, 3'd6}, {32'd2, 32'd3}, {32'd4, 32'd5}, {4'd1, 4'd2}, '0, '0, 2'b11, 0, RESET_MID);
    applyStimulus({3'd7, 3'd7}, {32'd2, 32'd3}, {32'd4, 32'd5}, {4'd1, 4'd2}, '0, '0, 2'b11, 0, NO_FLUSH);

    repeat (L + 4) stepCycle();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter CH, default 2: number of issue channels.
REQ-002 Parameter W, default 32: datapath width per channel.
REQ-003 Parameter MUL_LAT, default 3, legal range 2..15: MUL bundle latency in cycles.
REQ-004 Ports, listed as name  direction  width  meaning:
- clock  in  1  clock; nReset  in  1  reset.
- in_valid  in  1  bundle offered; in_ready  out  1  bundle can be accepted.
- flush  in  1  synchronous abort of the in-flight bundle.
- op  in  CH*3  per-channel opcode; wn  in  CH*4  destination register; wreg  in  CH  write enable.
- da, db  in  CH*W  operands; rn_a, rn_b  in  CH*4  source register numbers of da/db.
- out_valid  out  1  retire pulse; ed  out  CH*W  results; ewn  out  CH*4  destinations; ewreg  out  CH  write enables.
- neg, zero  out  CH  result flags.
REQ-005 Reset nReset, asynchronous, active-low; clock clock.
REQ-006 Channel c occupies bits [c*W+W-1:c*W] of ed/da/db and bits [c*4+3:c*4] of wn/ewn/rn_a/rn_b.

Function
REQ-007 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 MOV a; 6 MUL low W bits of a*b; 7 NOP (ewreg forced 0, ed=0).
REQ-008 Arithmetic is modulo 2^W; carry and overflow are discarded.
REQ-009 FSM states: IDLE, BUSY.
REQ-010 in_ready = 1 in IDLE and 0 in BUSY (combinational from state); acceptance = in_valid & in_ready & ~flush.
REQ-011 Non-MUL bundle: results registered at the acceptance edge; out_valid = 1 for exactly the next cycle; FSM stays IDLE.
REQ-012 A bundle with any channel op=6 enters BUSY with counter = MUL_LAT-1.
REQ-013 In BUSY the counter decrements each cycle; at the edge where the counter is 1, all channels retire together, out_valid pulses for 1 cycle, and the FSM returns to IDLE.
REQ-014 A MUL bundle's out_valid appears MUL_LAT cycles after acceptance; in_ready is 0 for MUL_LAT-1 cycles.
REQ-015 Back-to-back: in_ready is 1 in the out_valid cycle, so a new bundle may be accepted in that same cycle.
REQ-016 ed/ewn are held between retires; ewreg[c] = registered wreg[c] & out_valid, so ewreg is 0 when out_valid is 0.
REQ-017 zero[c] = ~|ed[c] and neg[c] = ed[c][W-1]; both are combinational from the registered ed.
REQ-018 Flush in IDLE: nothing is accepted and out_valid is 0 next cycle.
REQ-019 Flush in BUSY: return to IDLE next edge, no out_valid, ed/ewn unchanged.
REQ-020 Flush coincident with the retire edge: flush wins and the retire is suppressed.
REQ-021 Operands are latched at acceptance; input changes during BUSY have no effect.

Reset
REQ-022 On nReset low: state=IDLE, counter=0, out_valid=0, ed=0, ewn=0, ewreg=0 (so zero=all 1s, neg=0).
REQ-023 Reset mid-BUSY discards the bundle; in_ready=1 in the first cycle after release.

Configuration
REQ-024 Macro EXEC_STAGE_MC_BYPASS_EN, when defined, enables result forwarding.
- Forwarding applies when accepting in a cycle with out_valid=1.
- Each operand whose rn equals ewn[k] with ewreg[k]=1 is replaced by ed[k].
- If several channels match, the highest k wins.
REQ-025 When EXEC_STAGE_MC_BYPASS_EN is undefined, rn_a/rn_b are ignored and operands are used as given; ports are identical in both builds.

Verification
REQ-026 CH=2, W=32: ch0 ADD 0xFFFFFFFF+1, ch1 SUB 5-7 -> one cycle later out_valid=1, ed0=0, zero0=1, ed1=0xFFFFFFFE, neg1=1.
REQ-027 MUL_LAT=3: ch0 MUL 0x10000*0x10000, ch1 MOV 9 -> in_ready=0 for 2 cycles; out_valid in cycle 3; ed0=0, ed1=9 simultaneously.
REQ-028 MUL bundle accepted, flush asserted 1 cycle later -> no out_valid, in_ready=1 next cycle, ed holds previous values.
REQ-029 Bypass build: retire ch0 wn=3 ed=0x10 and ch1 wn=3 ed=0x20 (both wreg=1), accept in the same cycle ch0 ADD rn_a=3 da=0 db=1 -> ed0=0x21; non-bypass build -> ed0=1.
REQ-030 nReset asserted during BUSY -> out_valid=0, zero=all 1s; a post-release NOP bundle gives ewreg=0 with out_valid=1.
